// File: rtl/trit_rz_tx.sv
// trit_rz_tx: 1-of-3 return-to-zero transmitter with a symbol FIFO and a synchronized ack handshake.
// Build option: define TRIT_TX_TMR_EN to replicate the rail word on all three lanes of rail_out.
module trit_rz_tx #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_trit,
    output logic [8:0] rail_out,
    input  logic       ack_in,
    output logic       busy,
    output logic       err_illegal,
    output logic       err_timeout,
    input  logic       clr_err
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_NULL} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_reg, rd_ptr_reg;
    logic        ack_meta_reg, ack_sync_reg;
    logic [15:0] cnt_reg, cnt_next;
    logic [2:0]  rail_reg, rail_next;
    logic        err_illegal_reg, err_timeout_reg;

    logic        fifo_empty, fifo_full, accept, push, illegal, pop, timeout, to_fire;
    logic [1:0]  head;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign in_ready   = !fifo_full;
    assign accept     = in_valid && in_ready;
    assign push       = accept && (in_trit != 2'b11);
    assign illegal    = accept && (in_trit == 2'b11);
    assign head       = fifo_mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg[AW-1:0]] <= in_trit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_meta_reg <= 1'b0;
            ack_sync_reg <= 1'b0;
        end else begin
            ack_meta_reg <= ack_in;
            ack_sync_reg <= ack_meta_reg;
        end
    end

    assign timeout = TO_EN && (state_reg != ST_IDLE) && (cnt_reg == TO_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (!fifo_empty && !ack_sync_reg) state_next = ST_DATA;
            ST_DATA: if (ack_sync_reg || timeout)      state_next = ST_NULL;
            ST_NULL: if (!ack_sync_reg)                state_next = ST_IDLE;
            default:                                   state_next = ST_IDLE;
        endcase
    end

    // Output logic: pop strobe, next rail word, timeout event
    always_comb begin
        pop       = 1'b0;
        rail_next = rail_reg;
        to_fire   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty && !ack_sync_reg) begin
                    pop       = 1'b1;
                    rail_next = 3'b001 << head;
                end
            end
            ST_DATA: begin
                if (ack_sync_reg) begin
                    rail_next = 3'b000;
                end else if (timeout) begin
                    rail_next = 3'b000;
                    to_fire   = 1'b1;
                end
            end
            ST_NULL: begin
                rail_next = 3'b000;
                if (ack_sync_reg && timeout)
                    to_fire = 1'b1;
            end
            default: rail_next = 3'b000;
        endcase
    end

    // Counter restarts on every state change and saturates at the timeout point.
    always_comb begin
        cnt_next = cnt_reg;
        if (state_next != state_reg)
            cnt_next = 16'd0;
        else if (state_reg != ST_IDLE && cnt_reg != TO_LAST)
            cnt_next = cnt_reg + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg         <= 16'd0;
            rail_reg        <= 3'b000;
            err_illegal_reg <= 1'b0;
            err_timeout_reg <= 1'b0;
        end else begin
            cnt_reg         <= cnt_next;
            rail_reg        <= rail_next;
            err_illegal_reg <= illegal | (err_illegal_reg & ~clr_err);
            err_timeout_reg <= to_fire | (err_timeout_reg & ~clr_err);
        end
    end

    assign err_illegal = err_illegal_reg;
    assign err_timeout = err_timeout_reg;
    assign busy        = (state_reg != ST_IDLE) || !fifo_empty;

`ifdef TRIT_TX_TMR_EN
    assign rail_out = {3{rail_reg}};
`else
    assign rail_out = {6'b000_000, rail_reg};
`endif

endmodule

// File: tb/tb_trit_rz_tx.sv
// tb_trit_rz_tx: randomized self-checking bench for trit_rz_tx against a per-cycle timeline model.
// The expected lane layout follows TRIT_TX_TMR_EN the same way the design build does.
module tb_trit_rz_tx;
    localparam int DEPTH = 4;
    localparam int TO    = 8;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_trit  = 2'b00;
    logic       clr_err  = 1'b0;
    logic       loopback = 1'b1;
    logic       in_ready, ack_in, busy, err_illegal, err_timeout;
    logic [8:0] rail_out;

    int total = 0;
    int bad   = 0;

    logic [1:0] stim [8];
    int         stim_n;

    trit_rz_tx #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_trit     (in_trit),
        .rail_out    (rail_out),
        .ack_in      (ack_in),
        .busy        (busy),
        .err_illegal (err_illegal),
        .err_timeout (err_timeout),
        .clr_err     (clr_err)
    );

    always #5 clk = ~clk;

    // Receiver stand-in: completion follows the OR of lane 0 with no delay.
    assign ack_in = loopback && (rail_out[2:0] != 3'b000);

    function automatic logic [8:0] lanes(input logic [2:0] w);
`ifdef TRIT_TX_TMR_EN
        return {w, w, w};
`else
        return {6'b000_000, w};
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; clr_err = 1'b0; loopback = 1'b1;
        repeat (2) step();
        total++; if (rail_out !== 9'd0) begin bad++; $display("FAIL reset_rail got=%b want=0", rail_out); end
        rst_n = 1'b1;
        step();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (err_illegal !== 1'b0) begin bad++; $display("FAIL reset_err_illegal got=%b want=0", err_illegal); end
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL reset_err_timeout got=%b want=0", err_timeout); end
        $display("reset: done");
    endtask

    // Pushes stim[0..stim_n-1] on consecutive edges with ack looped back and checks every cycle.
    // Model: legal symbol m pops at max(push+1, previous pop+7); rails show it for 3 cycles;
    // the handshake returns to IDLE 6 cycles after the pop.
    task automatic run_stream(input string tag);
        int         push_at [8];
        int         pop_at  [8];
        logic [2:0] oh      [8];
        int         nleg    = 0;
        int         prev    = -100;
        bit         any_ill = 1'b0;
        int         last;
        logic [2:0] exp_w;
        logic       exp_b;
        for (int i = 0; i < stim_n; i++) begin
            if (stim[i] == 2'b11) begin
                any_ill = 1'b1;
            end else begin
                push_at[nleg] = i;
                pop_at[nleg]  = (i + 1 > prev + 7) ? i + 1 : prev + 7;
                prev          = pop_at[nleg];
                oh[nleg]      = 3'b001 << stim[i];
                nleg++;
            end
        end
        last = (nleg == 0) ? stim_n + 2 : prev + 8;
        for (int e = 0; e <= last; e++) begin
            if (e < stim_n) begin
                in_valid = 1'b1;
                in_trit  = stim[e];
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_ready e=%0d got=%b want=1", tag, e, in_ready); end
            end else begin
                in_valid = 1'b0;
            end
            step();
            exp_w = 3'b000;
            exp_b = 1'b0;
            for (int m = 0; m < nleg; m++) begin
                if (e >= pop_at[m] && e < pop_at[m] + 3) exp_w = oh[m];
                if (e >= push_at[m] && e < pop_at[m] + 6) exp_b = 1'b1;
            end
            total++; if (rail_out !== lanes(exp_w)) begin bad++; $display("FAIL %s_rail e=%0d got=%b want=%b", tag, e, rail_out, lanes(exp_w)); end
            total++; if (busy !== exp_b) begin bad++; $display("FAIL %s_busy e=%0d got=%b want=%b", tag, e, busy, exp_b); end
        end
        in_valid = 1'b0;
        total++; if (err_illegal !== any_ill) begin bad++; $display("FAIL %s_err_illegal got=%b want=%b", tag, err_illegal, any_ill); end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        total++; if (err_illegal !== 1'b0) begin bad++; $display("FAIL %s_clr_illegal got=%b want=0", tag, err_illegal); end
        $display("stream %s: pushed=%0d legal=%0d", tag, stim_n, nleg);
    endtask

    task automatic test_loopback_012();
        stim[0] = 2'd0; stim[1] = 2'd1; stim[2] = 2'd2; stim_n = 3;
        run_stream("seq012");
    endtask

    task automatic test_illegal();
        stim[0] = 2'd1; stim[1] = 2'b11; stim[2] = 2'd2; stim_n = 3;
        run_stream("illegal");
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            stim_n = int'($urandom_range(1, 5));
            for (int i = 0; i < stim_n; i++) stim[i] = 2'($urandom_range(0, 3));
            run_stream($sformatf("rand%0d", r));
        end
    endtask

    task automatic test_fill();
        logic [1:0] syms [6];
        logic [2:0] got  [8];
        int         ngot = 0;
        logic [2:0] prev = 3'b000;
        int         c;
        loopback = 1'b0;
        for (int i = 0; i < 6; i++) begin
            syms[i]  = 2'($urandom_range(0, 2));
            in_valid = 1'b1;
            in_trit  = syms[i];
            total++; if (in_ready !== (i <= 4)) begin bad++; $display("FAIL fill_ready i=%0d got=%b want=%b", i, in_ready, (i <= 4)); end
            step();
        end
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_stall got=%b want=0", in_ready); end
        total++; if (rail_out !== lanes(3'b001 << syms[0])) begin bad++; $display("FAIL fill_data got=%b want=%b", rail_out, lanes(3'b001 << syms[0])); end
        loopback = 1'b1;
        for (c = 0; c < 120 && busy; c++) begin
            if (rail_out[2:0] != 3'b000 && prev == 3'b000 && ngot < 8) begin
                got[ngot] = rail_out[2:0];
                ngot++;
            end
            prev = rail_out[2:0];
            step();
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fill_drain_timeout busy=%b want=0", busy); end
        total++; if (ngot != 5) begin bad++; $display("FAIL fill_count got=%0d want=5", ngot); end
        for (int i = 0; i < 5 && i < ngot; i++) begin
            total++; if (got[i] !== (3'b001 << syms[i])) begin bad++; $display("FAIL fill_word i=%0d got=%b want=%b", i, got[i], 3'b001 << syms[i]); end
        end
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL fill_err_timeout got=%b want=0", err_timeout); end
        $display("fill: words=%0d", ngot);
    endtask

    task automatic test_timeout();
        logic [1:0] sym;
        logic [2:0] w;
        sym = 2'($urandom_range(0, 2));
        w   = 3'b001 << sym;
        loopback = 1'b0;
        in_valid = 1'b1; in_trit = sym;
        step();
        in_valid = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            if (e == 8) clr_err = 1'b1;
            step();
            total++; if (rail_out !== lanes((e <= 8) ? w : 3'b000)) begin bad++; $display("FAIL to_rail e=%0d got=%b want=%b", e, rail_out, lanes((e <= 8) ? w : 3'b000)); end
            total++; if (err_timeout !== (e == 9)) begin bad++; $display("FAIL to_flag e=%0d got=%b want=%b", e, err_timeout, (e == 9)); end
        end
        clr_err = 1'b0;
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_idle busy=%b want=0", busy); end
        total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b want=1", err_timeout); end
        loopback = 1'b1;
        stim[0] = 2'($urandom_range(0, 2)); stim_n = 1;
        run_stream("after_to");
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL to_clr got=%b want=0", err_timeout); end
        $display("timeout: sym=%0d", sym);
    endtask

    task automatic test_reset_mid();
        loopback = 1'b1;
        stim[0] = 2'b11; stim[1] = 2'd1; stim[2] = 2'd2; stim[3] = 2'd0;
        for (int e = 0; e < 4; e++) begin
            in_valid = 1'b1; in_trit = stim[e];
            step();
        end
        in_valid = 1'b0;
        total++; if (rail_out !== lanes(3'b010)) begin bad++; $display("FAIL rstmid_data got=%b want=%b", rail_out, lanes(3'b010)); end
        rst_n = 1'b0;
        #1;
        total++; if (rail_out !== 9'd0) begin bad++; $display("FAIL rstmid_async got=%b want=0", rail_out); end
        total++; if (err_illegal !== 1'b0) begin bad++; $display("FAIL rstmid_err got=%b want=0", err_illegal); end
        repeat (2) step();
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            total++; if (rail_out !== 9'd0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_quiet c=%0d rail=%b busy=%b want=0/0", c, rail_out, busy); end
        end
        total++; if (in_ready !== 1'b1 || err_timeout !== 1'b0) begin bad++; $display("FAIL rstmid_state ready=%b err_to=%b want=1/0", in_ready, err_timeout); end
        $display("reset_mid: done");
    endtask

    task automatic test_lanes_push1();
        stim[0] = 2'd1; stim_n = 1;
        run_stream("push1");
    endtask

    initial begin
        test_reset();
        test_loopback_012();
        test_lanes_push1();
        test_illegal();
        test_random();
        test_fill();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
